// File: rtl/scan_ctrl_7x64.sv
// scan_ctrl_7x64: walks the display bank of a double-buffered 7x64 framebuffer and
// serialises each word MSB-first onto an LED driver chain, latching after every word.
module scan_ctrl_7x64 #(
    parameter int FRAME_WORDS = 64,
    parameter int CLK_DIV     = 2,
    parameter int LATCH_LEN   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        swap_req_i,
    output logic [6:0]  addrb_o,
    input  logic [63:0] dob_i,
    output logic        sdata_o,
    output logic        sclk_o,
    output logic        slatch_o,
    output logic        disp_bank_o,
    output logic        swap_ack_o,
    output logic        frame_done_o
);
    localparam int DW = $clog2(2 * CLK_DIV) + 1;
    localparam int LW = $clog2(LATCH_LEN) + 1;
    localparam logic [DW-1:0] DIV_HI    = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_LEN - 1);
    localparam logic [5:0]    LAST_WORD = 6'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, LATCH, EOF} state_t;

    state_t        state_q;
    logic [63:0]   shreg_q;
    logic [5:0]    word_q;
    logic [5:0]    bit_q;
    logic [DW-1:0] div_q;
    logic [LW-1:0] lat_q;
    logic          sclk_q;
    logic          slatch_q;
    logic          bank_q;
    logic          ack_q;
    logic          done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            word_q   <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            lat_q    <= '0;
            sclk_q   <= 1'b0;
            slatch_q <= 1'b0;
            bank_q   <= 1'b0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE:  if (enable_i) state_q <= FETCH;
                FETCH: state_q <= LOAD;
                LOAD: begin
                    shreg_q <= dob_i;
                    bit_q   <= '0;
                    div_q   <= '0;
                    sclk_q  <= 1'b0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    // the fully shifted-out register is all zero, so sdata idles low
                    if (div_q == DIV_LAST) begin
                        shreg_q <= {shreg_q[62:0], 1'b0};
                        bit_q   <= bit_q + 6'd1;
                        div_q   <= '0;
                        sclk_q  <= 1'b0;
                        if (bit_q == 6'd63) begin
                            slatch_q <= 1'b1;
                            lat_q    <= '0;
                            state_q  <= LATCH;
                        end
                    end else begin
                        div_q  <= div_q + 1'b1;
                        sclk_q <= div_q >= DIV_HI;
                    end
                end
                LATCH: begin
                    if (lat_q == LAT_LAST) begin
                        slatch_q <= 1'b0;
                        if (word_q == LAST_WORD) begin
                            done_q  <= 1'b1;
                            state_q <= EOF;
                        end else begin
                            word_q  <= word_q + 6'd1;
                            state_q <= enable_i ? FETCH : IDLE;
                        end
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end
                EOF: begin
                    // the ack is visible in the first cycle the new bank is displayed
                    word_q  <= '0;
                    bank_q  <= bank_q ^ swap_req_i;
                    ack_q   <= swap_req_i;
                    state_q <= enable_i ? FETCH : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addrb_o      = {bank_q, word_q};
    assign sdata_o      = shreg_q[63];
    assign sclk_o       = sclk_q;
    assign slatch_o     = slatch_q;
    assign disp_bank_o  = bank_q;
    assign swap_ack_o   = ack_q;
    assign frame_done_o = done_q;
endmodule

// File: tb/tb_scan_ctrl_7x64.sv
// tb_scan_ctrl_7x64: directed checks of the scan controller; instance a uses default
// parameters, instance b a 4-word frame with CLK_DIV=1 and LATCH_LEN=1.
module tb_scan_ctrl_7x64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        en_a = 1'b0, swap_a = 1'b0;
    logic [6:0]  addr_a;
    logic [63:0] dob_a = '0;
    logic        sdata_a, sclk_a, slatch_a, bank_a, ack_a, done_a;
    logic        en_b = 1'b0, swap_b = 1'b0;
    logic [6:0]  addr_b;
    logic [63:0] dob_b = '0;
    logic        sdata_b, sclk_b, slatch_b, bank_b, ack_b, done_b;

    scan_ctrl_7x64 u_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en_a), .swap_req_i(swap_a), .addrb_o(addr_a),
        .dob_i(dob_a), .sdata_o(sdata_a), .sclk_o(sclk_a), .slatch_o(slatch_a),
        .disp_bank_o(bank_a), .swap_ack_o(ack_a), .frame_done_o(done_a)
    );

    scan_ctrl_7x64 #(.FRAME_WORDS(4), .CLK_DIV(1), .LATCH_LEN(1)) u_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en_b), .swap_req_i(swap_b), .addrb_o(addr_b),
        .dob_i(dob_b), .sdata_o(sdata_b), .sclk_o(sclk_b), .slatch_o(slatch_b),
        .disp_bank_o(bank_b), .swap_ack_o(ack_b), .frame_done_o(done_b)
    );

    function automatic logic [63:0] pat(int i);
        return 64'h0123_4567_89AB_CDEF ^ {8{8'(i)}};
    endfunction

    logic [63:0] mem_a [128];
    logic [63:0] mem_b [128];
    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = pat(i);
            mem_b[i] = ~pat(i);
        end
        mem_a[0] = 64'h8000_0000_0000_0001;
    end
    always @(posedge clk) begin
        dob_a <= mem_a[addr_a];
        dob_b <= mem_b[addr_b];
    end

    // serial capture of instance a at sclk rises
    logic [63:0] cap_a = '0;
    int          bits_a = 0;
    logic        psclk_a = 1'b0;
    always @(negedge clk) begin
        if (sclk_a && !psclk_a) begin
            cap_a = {cap_a[62:0], sdata_a};
            bits_a++;
        end
        psclk_a = sclk_a;
    end

    // event log of instance b
    int         cyc = 0, acks_b = 0, bchg_b = 0;
    int         dq[$];
    logic [6:0] aq[$];
    logic [6:0] paddr_b = '0;
    logic       pbank_b = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (done_b) dq.push_back(cyc);
        if (addr_b != paddr_b) aq.push_back(addr_b);
        if (ack_b) acks_b++;
        if (bank_b != pbank_b) bchg_b++;
        paddr_b = addr_b;
        pbank_b = bank_b;
    end

    int passed = 0, total = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en;
        logic [6:0] addr;
        logic       sclk;
        logic       slatch;
        logic       sdata;
    } vec_t;
    vec_t tv[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic early, pb;
        tv[0] = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 7'h00, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 7'h00, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b1, 7'h00, 1'b0, 1'b0, 1'b1};
        tv[4] = '{1'b1, 7'h00, 1'b0, 1'b0, 1'b1};
        tv[5] = '{1'b1, 7'h00, 1'b1, 1'b0, 1'b1};
        tv[6] = '{1'b1, 7'h00, 1'b1, 1'b0, 1'b1};
        tv[7] = '{1'b1, 7'h00, 1'b0, 1'b0, 1'b0};

        repeat (3) step();
        chk("rst_a", {addr_a, sdata_a, sclk_a, slatch_a, bank_a, ack_a, done_a}, '0);
        chk("rst_b", {addr_b, sdata_b, sclk_b, slatch_b, bank_b, ack_b, done_b}, '0);
        @(negedge clk);
        rst = 1'b0;

        // start-up timing of word 0: first sclk rise five edges after enable
        for (int i = 0; i < 8; i++) begin
            en_a = tv[i].en;
            step();
            chk($sformatf("vec%0d_addr", i), addr_a, tv[i].addr);
            chk($sformatf("vec%0d_sclk", i), sclk_a, tv[i].sclk);
            chk($sformatf("vec%0d_slatch", i), slatch_a, tv[i].slatch);
            chk($sformatf("vec%0d_sdata", i), sdata_a, tv[i].sdata);
        end

        for (n = 0; n < 1000 && !slatch_a; n++) step();
        chk("t1_latch_wait", n < 1000, 1);
        chk("t1_word0", cap_a, 64'h8000_0000_0000_0001);
        chk("t1_bits", bits_a, 64);
        chk("t1_sdata_latch", sdata_a, 0);
        for (n = 0; n < 100 && slatch_a; n++) step();
        chk("t1_latch_len", n, 4);
        chk("t1_next_addr", addr_a, 7'h01);

        // enable dropped during bit 10 of word 2
        for (n = 0; n < 3000 && bits_a < 139; n++) step();
        chk("t4_bit10_wait", n < 3000, 1);
        en_a = 1'b0;
        for (n = 0; n < 1000 && !slatch_a; n++) step();
        chk("t4_latch_wait", n < 1000, 1);
        chk("t4_word2", cap_a, mem_a[2]);
        chk("t4_bits2", bits_a, 192);
        for (n = 0; n < 100 && slatch_a; n++) step();
        repeat (20) step();
        chk("t4_idle_addr", addr_a, 7'h03);
        chk("t4_idle_bits", bits_a, 192);
        chk("t4_idle_sclk", sclk_a, 0);
        en_a = 1'b1;
        for (n = 0; n < 1000 && !slatch_a; n++) step();
        chk("t4_word3", cap_a, mem_a[3]);
        chk("t4_bits3", bits_a, 256);
        en_a = 1'b0;

        // frame period, address walk and no swap without request
        en_b = 1'b1;
        for (n = 0; n < 4000 && dq.size() < 4; n++) step();
        chk("t2_frames_wait", dq.size() >= 4, 1);
        if (dq.size() >= 4) begin
            chk("t2_period0", dq[1] - dq[0], 525);
            chk("t2_period1", dq[2] - dq[1], 525);
            chk("t2_period2", dq[3] - dq[2], 525);
        end
        chk("t2_addr_seq", {aq[0], aq[1], aq[2], aq[3], aq[4]}, {7'd1, 7'd2, 7'd3, 7'd0, 7'd1});
        chk("t6_no_ack", acks_b, 0);
        chk("t6_no_bank_change", bchg_b, 0);
        chk("t6_bank", bank_b, 0);

        // swap requested mid-frame
        for (n = 0; n < 600 && addr_b != 7'h02; n++) step();
        chk("t3_mid_wait", n < 600, 1);
        swap_b = 1'b1;
        early = 1'b0;
        pb = bank_b;
        for (n = 0; n < 1000; n++) begin
            pb = bank_b;
            step();
            if (ack_b) break;
            if (bank_b) early = 1'b1;
        end
        chk("t3_ack_wait", n < 1000, 1);
        chk("t3_no_early_bank", early, 0);
        chk("t3_bank_before", pb, 0);
        chk("t3_bank_at_ack", bank_b, 1);
        chk("t3_fetch_addr", addr_b, 7'h40);
        swap_b = 1'b0;
        step();
        chk("t3_ack_pulse", ack_b, 0);

        // asynchronous reset during SHIFT with bank 1
        for (n = 0; n < 100 && !sclk_b; n++) step();
        chk("t5_shift_bank", {sclk_b, bank_b}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_rst", {addr_b, sdata_b, sclk_b, slatch_b, bank_b, ack_b, done_b}, '0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t5_restart_addr", addr_b, 7'h00);
        for (n = 0; n < 600 && !slatch_b; n++) step();
        chk("t5_first_latch_addr", {n < 600, addr_b}, {1'b1, 7'h00});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
